seven_seg_scanner: RTL
======================

Name: seven_seg_scanner

Overview:
- Downstream consumer of the core wrapper's 32-bit SEVENSEGHEX output. Drives an 8-digit, common-anode, time-multiplexed seven-segment display on the board.
- Snapshots the hex value once per frame so the display never tears.
- Scans one digit at a time, with a blanking gap between digits to suppress ghosting.
- Supports optional leading-zero suppression and per-digit decimal points.

Parameters:
- NUM_DIGITS, 8: digits scanned, one nibble of SEVENSEGHEX each; nibble k drives digit k.
- REFRESH_DIV, 100000: clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- SEVENSEGHEX  in  32  hex value to display; digit 0 is bits [3:0].
- DP_EN  in  NUM_DIGITS  decimal-point enable per digit.
- LZ_EN  in  1  leading-zero suppression enable.
- ANODE  out  NUM_DIGITS  digit enables, active-low.
- CATHODE  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DP_N  out  1  decimal-point segment, active-low.

Behaviour:
- Reset (RESET=0, takes effect asynchronously):
  - ANODE=all ones, CATHODE=7'h7F, DP_N=1.
  - cnt=0, idx=0, snap_hex=0, snap_dp=0.
- Counters:
  - cnt runs 0..REFRESH_DIV-1, then wraps to 0 and increments idx.
  - idx runs 0..NUM_DIGITS-1, then wraps to 0.
  - Frame = NUM_DIGITS*REFRESH_DIV cycles.
- Snapshot:
  - On every clock edge where cnt==0 && idx==0, snap_hex<=SEVENSEGHEX and snap_dp<=DP_EN.
  - This includes the first edge after reset release.
  - Input changes at any other time do not affect the current frame.
- Slot phases, a two-state FSM derived from cnt:
  - BLANK while cnt < BLANK_CYCLES: all anodes high, CATHODE=7'h7F, DP_N=1.
  - SHOW otherwise: ANODE bit idx low, all other bits high.
  - In SHOW, CATHODE=decode(snap_hex nibble idx) and DP_N=~snap_dp[idx].
- Outputs are registered: the outputs in cycle t+1 reflect cnt/idx/snap in cycle t (1-cycle latency).
  - Because BLANK_CYCLES>=1, the snapshot load edge always falls inside BLANK, so no stale nibble is ever lit.
- Leading-zero suppression (LZ_EN=1):
  - Digit k>0 is suppressed if snap_hex nibbles k..NUM_DIGITS-1 are all zero.
  - A suppressed digit is treated as BLANK for its whole slot: anodes high, DP_N=1.
  - Digit 0 is never suppressed.
  - LZ_EN is sampled live, not snapshotted.
- Decode (active-low {g..a}):
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex values).
- Invariant: at most one ANODE bit is low in any cycle.
- Reset mid-scan: outputs blank immediately. After release, scanning restarts at digit 0, slot cycle 0, with a fresh snapshot.
- Width rules:
  - cnt width is clog2(REFRESH_DIV).
  - idx width is clog2(NUM_DIGITS), minimum 1.
  - Wrap is by compare to the parameter, never by natural overflow.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16-entry active-low segment constant table;
  - the SEG_OFF=7'h7F constant;
  - the ANODE_OFF helper.
- Sub-module hex_to_7seg: combinational nibble-to-segment decoder using the package table, instantiated once in the scanner.

Test Plan (REFRESH_DIV=4, BLANK_CYCLES=1, NUM_DIGITS=8; frame = 32 cycles):
1. Hold RESET=0 mid-frame -> ANODE=8'hFF, CATHODE=7'h7F and DP_N=1 in the same cycle, with no clock edge required.
2. SEVENSEGHEX=32'h000000A1, LZ_EN=0, DP_EN=0:
   - Each slot is 1 blank cycle, then 3 lit cycles.
   - Slot 0: ANODE=8'hFE, CATHODE=7'h79.
   - Slot 1: ANODE=8'hFD, CATHODE=7'h08.
   - Slots 2-7: CATHODE=7'h40.
3. Same value with LZ_EN=1 -> slots 2-7 keep ANODE=8'hFF. Then SEVENSEGHEX=0 -> only digit 0 lights, with 7'h40.
4. SEVENSEGHEX=32'h11111111, changed to 32'h22222222 at cycle 10 of a frame -> the rest of that frame shows 7'h79; the next frame shows 7'h24 on all digits.
5. Assert RESET low during slot 5, release 3 cycles later -> blank while reset is asserted, then digit 0 lit 2 cycles after release with the new snapshot.
6. DP_EN=8'h01 -> DP_N=0 only during digit 0's lit cycles; DP_N=1 everywhere else. Assertion checks at most one ANODE bit low at any time.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: segment table, blank
// patterns and the phase encoding used by the slot FSM.
package seven_seg_pkg;

  // Widest display this scanner supports (one nibble per digit of 32 bits).
  localparam int MAX_DIGITS = 8;
  localparam int MAX_IDX_W  = $clog2(MAX_DIGITS);

  // All segments dark (active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // All anodes dark (active-low).
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = {MAX_DIGITS{1'b1}};

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Slot phase: anodes forced off during BLANK to suppress ghosting.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_e;

  // Anode pattern with only digit idx enabled (active-low).
  function automatic logic [MAX_DIGITS-1:0] anode_sel(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_DIGITS-1:0] a;
    a      = ANODE_OFF;
    a[idx] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup; every nibble value has an entry.
  always_comb begin
    seg_o = SEG_TABLE[nibble_i];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a common-anode seven-segment display.
// The hex value is captured once per frame so digits never tear; each digit
// slot opens with a blanking gap, and outputs are registered (1-cycle latency).
// NUM_DIGITS must not exceed 8 (one nibble per digit of SEVENSEGHEX).
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           SEVENSEGHEX,
  input  logic [NUM_DIGITS-1:0] DP_EN,
  input  logic                  LZ_EN,
  output logic [NUM_DIGITS-1:0] ANODE,
  output logic [6:0]            CATHODE,
  output logic                  DP_N
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODES_DARK = ANODE_OFF[NUM_DIGITS-1:0];

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [31:0]           snap_hex_q, snap_hex_d;
  logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            cathode_q, cathode_d;
  logic                  dp_n_q, dp_n_d;

  logic                  load_s;
  logic [3:0]            nibble_s;
  logic                  nonzero_above_s;
  logic                  suppress_s;
  logic [6:0]            seg_s;
  logic [MAX_DIGITS-1:0] anode_sel_s;
  phase_e                phase_s;

  hex_to_7seg u_dec (
    .nibble_i (nibble_s),
    .seg_o    (seg_s)
  );

  // Slot and digit counters; wrap by compare, then snapshot at frame start.
  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1'b1);
    idx_d      = idx_q;
    load_s     = (cnt_q == '0) && (idx_q == '0);
    snap_hex_d = snap_hex_q;
    snap_dp_d  = snap_dp_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1'b1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end
    if (load_s) begin
      snap_hex_d = SEVENSEGHEX;
      snap_dp_d  = DP_EN;
    end else begin
      snap_hex_d = snap_hex_q;
      snap_dp_d  = snap_dp_q;
    end
  end

  // Pick the current digit's nibble and see whether anything at or above it is nonzero.
  always_comb begin
    nibble_s        = 4'h0;
    nonzero_above_s = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == idx_q) begin
        nibble_s = snap_hex_q[4*k +: 4];
      end else begin
        nibble_s = nibble_s;
      end
      if ((IDX_W'(k) >= idx_q) && (snap_hex_q[4*k +: 4] != 4'h0)) begin
        nonzero_above_s = 1'b1;
      end else begin
        nonzero_above_s = nonzero_above_s;
      end
    end
    // Digit 0 always shows, so a value of zero still displays "0".
    suppress_s = LZ_EN && (idx_q != '0) && !nonzero_above_s;
  end

  // Phase FSM decoded from the slot counter, and next output values.
  always_comb begin
    phase_s     = (cnt_q < CNT_BLANK) ? PH_BLANK : PH_SHOW;
    anode_sel_s = anode_sel(MAX_IDX_W'(idx_q));
    anode_d     = ANODES_DARK;
    cathode_d   = SEG_OFF;
    dp_n_d      = 1'b1;
    case (phase_s)
      PH_BLANK: begin
        anode_d   = ANODES_DARK;
        cathode_d = SEG_OFF;
        dp_n_d    = 1'b1;
      end
      PH_SHOW: begin
        if (suppress_s) begin
          anode_d   = ANODES_DARK;
          cathode_d = SEG_OFF;
          dp_n_d    = 1'b1;
        end else begin
          anode_d   = anode_sel_s[NUM_DIGITS-1:0];
          cathode_d = seg_s;
          dp_n_d    = ~snap_dp_q[idx_q];
        end
      end
      default: begin
        anode_d   = ANODES_DARK;
        cathode_d = SEG_OFF;
        dp_n_d    = 1'b1;
      end
    endcase
  end

  // Counter and snapshot registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      snap_hex_q <= 32'h0000_0000;
      snap_dp_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      snap_hex_q <= snap_hex_d;
      snap_dp_q  <= snap_dp_d;
    end
  end

  // Output registers; reset blanks the display immediately.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      anode_q   <= ANODES_DARK;
      cathode_q <= SEG_OFF;
      dp_n_q    <= 1'b1;
    end else begin
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
      dp_n_q    <= dp_n_d;
    end
  end

  assign ANODE   = anode_q;
  assign CATHODE = cathode_q;
  assign DP_N    = dp_n_q;

endmodule
